// File: rtl/bch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bch_pkg                                                     |
// | Brief   : Shared GF(2^m) types, BCH defaults, FSM encoding and        |
// |           constant-multiplier helper functions.                       |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package bch_pkg;

   localparam int GF_M      = 8;
   localparam int BCH_T     = 4;
   localparam int BCH_N     = 255;
   localparam int GF_IRRPOL = 285;
   localparam int PTR_W     = 8;

   typedef logic [GF_M-1:0]  data_t;
   typedef logic [PTR_W-1:0] ptr_t;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Multiplicative group order and the reduction polynomial without x^m
   localparam int    c_gf_ord  = (1 << GF_M) - 1;
   localparam data_t c_irr_low = data_t'(GF_IRRPOL);

   // Multiply by alpha (x) and reduce
   function automatic data_t gf_xtime(input data_t a);
      data_t s;
      s = a << 1;
      if (a[GF_M-1]) s = s ^ c_irr_low;
      return s;
   endfunction

   // Generic shift-and-add GF(2^m) product; with a constant b it
   // collapses to a fixed XOR network
   function automatic data_t gf_mult_a_by_b(input data_t a, input data_t b);
      data_t acc;
      data_t sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < GF_M; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = gf_xtime(sh);
      end
      return acc;
   endfunction

   // alpha^e, used only to build elaboration-time constants
   function automatic data_t gf_pow_alpha(input int e);
      data_t r;
      int    ee;
      ee = e % c_gf_ord;
      r  = data_t'(1);
      for (int i = 0; i < ee; i++) r = gf_xtime(r);
      return r;
   endfunction

   // a * alpha^e with e fixed at elaboration
   function automatic data_t gf_const_mult(input data_t a, input int e);
      return gf_mult_a_by_b(a, gf_pow_alpha(e));
   endfunction

endpackage
`default_nettype wire

// File: rtl/bch_chien_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bch_chien_cell                                              |
// | Brief   : One Chien term register r[j]. Loads L[j] scaled for the     |
// |           shortened start position, then steps by alpha^j per cycle.  |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module bch_chien_cell
   import bch_pkg::*;
#(
   parameter int J = 0,
   parameter int N = BCH_N
) (
   input  logic  iclk,
   input  logic  ireset,
   input  logic  iload,
   input  logic  istep,
   input  data_t iload_val,
   output data_t oterm
);

   // Start exponent so that step k evaluates at alpha^-(n-1-k)
   localparam int c_init_exp = (J * ((1 << GF_M) - N)) % c_gf_ord;
   localparam int c_step_exp = J % c_gf_ord;

   data_t r_term;

   // Term register: constant-scaled load, constant alpha^j update
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_term <= '0;
      end else if (iload) begin
         r_term <= gf_const_mult(iload_val, c_init_exp);
      end else if (istep) begin
         r_term <= gf_const_mult(r_term, c_step_exp);
      end
   end

   assign oterm = r_term;

endmodule
`default_nettype wire

// File: rtl/bch_chien_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bch_chien_search                                            |
// | Brief   : Chien search over the BCH error-locator polynomial. Emits   |
// |           one error flag per codeword bit, highest position first,    |
// |           plus root count and decode-fail verdict on the last bit.    |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module bch_chien_search
   import bch_pkg::*;
#(
   parameter int T = BCH_T,
   parameter int N = BCH_N
) (
   input  logic                  iclk,
   input  logic                  ireset,
   input  logic                  iloc_poly_val,
   input  logic [(T+1)*GF_M-1:0] iloc_poly,
   input  ptr_t                  iloc_poly_ptr,
   input  logic                  iloc_failed,
   output logic                  ordy,
   output logic                  oval,
   output logic                  oerr,
   output logic                  osop,
   output logic                  oeop,
   output ptr_t                  oerr_cnt,
   output logic                  odecfail,
   output ptr_t                  otag
);

   localparam int c_kw = (N > 1) ? $clog2(N) : 1;
   localparam int c_dw = $clog2(T + 1);

   state_t          r_state;
   logic [c_kw-1:0] r_k;
   ptr_t            r_cnt;
   logic [c_dw-1:0] r_deg;
   logic            r_fail;
   logic            r_zero;
   ptr_t            r_tag;
   logic            r_ordy;
   logic            r_oval;
   logic            r_oerr;
   logic            r_osop;
   logic            r_oeop;
   ptr_t            r_oerr_cnt;
   logic            r_odecfail;

   data_t           w_coef [0:T];
   data_t           w_term [0:T];
   data_t           w_sum;
   logic [c_dw-1:0] w_deg;
   logic            w_zero;
   logic            w_load;
   logic            w_step;
   logic            w_hit;
   logic            w_last;
   ptr_t            w_cnt_next;

   assign w_load = (r_state == S_IDLE) && iloc_poly_val;
   assign w_step = (r_state == S_RUN);

   // One term register per locator coefficient
   for (genvar j = 0; j <= T; j++) begin : g_cell
      assign w_coef[j] = iloc_poly[j*GF_M +: GF_M];

      bch_chien_cell #(
         .J (j),
         .N (N)
      ) u_cell (
         .iclk      (iclk),
         .ireset    (ireset),
         .iload     (w_load),
         .istep     (w_step),
         .iload_val (w_coef[j]),
         .oterm     (w_term[j])
      );
   end

   // Locator degree and all-zero detection on the incoming polynomial
   always_comb begin
      w_deg  = '0;
      w_zero = 1'b1;
      for (int j = 0; j <= T; j++) begin
         if (w_coef[j] != '0) begin
            w_deg  = c_dw'(j);
            w_zero = 1'b0;
         end
      end
   end

   // L(alpha^-p) as the XOR of all terms
   always_comb begin
      w_sum = '0;
      for (int j = 0; j <= T; j++) w_sum = w_sum ^ w_term[j];
   end

   // An all-zero locator evaluates to zero everywhere but has no roots
   assign w_hit      = (w_sum == '0) && !r_fail && !r_zero;
   assign w_last     = (r_k == c_kw'(N - 1));
   assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + ptr_t'(w_hit);

   // Control FSM, counters and the registered output stage
   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_state    <= S_IDLE;
         r_k        <= '0;
         r_cnt      <= '0;
         r_deg      <= '0;
         r_fail     <= 1'b0;
         r_zero     <= 1'b0;
         r_tag      <= '0;
         r_ordy     <= 1'b1;
         r_oval     <= 1'b0;
         r_oerr     <= 1'b0;
         r_osop     <= 1'b0;
         r_oeop     <= 1'b0;
         r_oerr_cnt <= '0;
         r_odecfail <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ordy     <= 1'b1;
               r_oval     <= 1'b0;
               r_oerr     <= 1'b0;
               r_osop     <= 1'b0;
               r_oeop     <= 1'b0;
               r_oerr_cnt <= '0;
               r_odecfail <= 1'b0;
               if (iloc_poly_val) begin
                  r_state <= S_RUN;
                  r_ordy  <= 1'b0;
                  r_k     <= '0;
                  r_cnt   <= '0;
                  r_deg   <= w_deg;
                  r_zero  <= w_zero;
                  r_fail  <= iloc_failed;
                  r_tag   <= iloc_poly_ptr;
               end
            end
            S_RUN: begin
               r_oval <= 1'b1;
               r_oerr <= w_hit;
               r_osop <= (r_k == '0);
               r_oeop <= w_last;
               r_cnt  <= w_cnt_next;
               if (w_last) begin
                  r_state    <= S_IDLE;
                  r_ordy     <= 1'b1;
                  r_oerr_cnt <= w_cnt_next;
                  r_odecfail <= r_fail || (w_cnt_next != ptr_t'(r_deg));
               end else begin
                  r_k        <= r_k + 1'b1;
                  r_oerr_cnt <= '0;
                  r_odecfail <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ordy     = r_ordy;
   assign oval     = r_oval;
   assign oerr     = r_oerr;
   assign osop     = r_osop;
   assign oeop     = r_oeop;
   assign oerr_cnt = r_oerr_cnt;
   assign odecfail = r_odecfail;
   assign otag     = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_bch_chien_search.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bch_chien_search                                         |
// | Brief   : Directed self-checking bench for bch_chien_search, full     |
// |           (n=255) and shortened (n=100) instances.                    |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_bch_chien_search;
   import bch_pkg::*;

   logic        iclk;
   logic        ireset;
   logic        val;
   logic        val_s;
   logic [39:0] poly;
   ptr_t        ptr;
   logic        failed;

   logic ordy, oval, oerr, osop, oeop, odecfail;
   ptr_t oerr_cnt, otag;
   logic ordy_s, oval_s, oerr_s, osop_s, oeop_s, odecfail_s;
   ptr_t oerr_cnt_s, otag_s;

   logic sel;
   logic m_ordy, m_oval, m_oerr, m_osop, m_oeop, m_odecfail;
   ptr_t m_oerr_cnt, m_otag;

   int n_checks = 0;
   int n_pass   = 0;

   int   f_lat, f_nval, f_sop_bad, f_eop_bad, f_side_bad, f_tag_chg;
   int   f_cnt, f_dec, f_tag;
   bit   f_err [0:254];

   bch_chien_search #(.T(4), .N(255)) dut (
      .iclk(iclk), .ireset(ireset), .iloc_poly_val(val), .iloc_poly(poly),
      .iloc_poly_ptr(ptr), .iloc_failed(failed), .ordy(ordy), .oval(oval),
      .oerr(oerr), .osop(osop), .oeop(oeop), .oerr_cnt(oerr_cnt),
      .odecfail(odecfail), .otag(otag)
   );

   bch_chien_search #(.T(4), .N(100)) dut_s (
      .iclk(iclk), .ireset(ireset), .iloc_poly_val(val_s), .iloc_poly(poly),
      .iloc_poly_ptr(ptr), .iloc_failed(failed), .ordy(ordy_s), .oval(oval_s),
      .oerr(oerr_s), .osop(osop_s), .oeop(oeop_s), .oerr_cnt(oerr_cnt_s),
      .odecfail(odecfail_s), .otag(otag_s)
   );

   assign m_ordy     = sel ? ordy_s     : ordy;
   assign m_oval     = sel ? oval_s     : oval;
   assign m_oerr     = sel ? oerr_s     : oerr;
   assign m_osop     = sel ? osop_s     : osop;
   assign m_oeop     = sel ? oeop_s     : oeop;
   assign m_oerr_cnt = sel ? oerr_cnt_s : oerr_cnt;
   assign m_odecfail = sel ? odecfail_s : odecfail;
   assign m_otag     = sel ? otag_s     : otag;

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   // Independent alpha^e model for poly 0x11D
   function automatic logic [7:0] tb_alpha_pow(input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < (e % 255); i++)
         r = r[7] ? ((r << 1) ^ 8'h1D) : (r << 1);
      return r;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   // Present one locator on the selected instance; returns after the capture edge
   task automatic send(input logic [39:0] p, input ptr_t tg, input logic fl);
      int w;
      w = 0;
      while (!m_ordy && w < 400) begin step(); w++; end
      if (!m_ordy) check("ordy_timeout", 0, 1);
      poly = p; ptr = tg; failed = fl;
      if (sel) val_s = 1'b1; else val = 1'b1;
      step();
      val = 1'b0; val_s = 1'b0;
   endtask

   // Record one frame of n outputs, starting just after the capture edge
   task automatic capture_frame(input int n);
      int w;
      f_lat = 0; f_nval = 0; f_sop_bad = 0; f_eop_bad = 0;
      f_side_bad = 0; f_tag_chg = 0; f_cnt = -1; f_dec = -1;
      for (int k = 0; k < 255; k++) f_err[k] = 1'b0;
      w = 0;
      while (!m_oval && w < 8) begin step(); w++; end
      f_lat = w;
      if (!m_oval) begin
         check("oval_timeout", 0, 1);
         return;
      end
      f_tag = int'(m_otag);
      for (int k = 0; k < n; k++) begin
         if (k > 0) step();
         if (m_oval) f_nval++;
         f_err[k] = m_oerr;
         if (m_osop != (k == 0))     f_sop_bad++;
         if (m_oeop != (k == n - 1)) f_eop_bad++;
         if (k != n - 1 && (m_oerr_cnt != 0 || m_odecfail)) f_side_bad++;
         if (int'(m_otag) != f_tag) f_tag_chg++;
      end
      f_cnt = int'(m_oerr_cnt);
      f_dec = int'(m_odecfail);
   endtask

   // Compare a recorded frame against expected error positions k1/k2 (-1 = none)
   task automatic check_frame(input string nm, input int n, input int k1, input int k2,
                              input int ecnt, input int edec, input int etag);
      int mism;
      mism = 0;
      for (int k = 0; k < n; k++)
         if (f_err[k] != ((k == k1) || (k == k2))) mism++;
      check({nm, ":latency"},  f_lat, 1);
      check({nm, ":nval"},     f_nval, n);
      check({nm, ":errmap"},   mism, 0);
      check({nm, ":sop_eop"},  f_sop_bad + f_eop_bad, 0);
      check({nm, ":side"},     f_side_bad + f_tag_chg, 0);
      check({nm, ":cnt"},      f_cnt, ecnt);
      check({nm, ":decfail"},  f_dec, edec);
      check({nm, ":tag"},      f_tag, etag);
      step();
      check({nm, ":idle_after"}, int'({m_oval, m_oeop, m_oerr_cnt != 0, m_odecfail}), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] p_single, p_double, p_short;
      p_single = {8'h00, 8'h00, 8'h00, 8'h20, 8'h01};        // 1 + a^5 x
      p_double = {8'h00, 8'h00, 8'h8E, 8'h8F, 8'h01};        // (1+x)(1+a^254 x)
      p_short  = {8'h00, 8'h00, 8'h00, tb_alpha_pow(200), 8'h01};

      sel = 1'b0; val = 1'b0; val_s = 1'b0; poly = '0; ptr = '0; failed = 1'b0;
      ireset = 1'b0;
      #22;
      check("rst:ordy", int'(ordy), 1);
      check("rst:outs", int'({oval, oerr, osop, oeop, odecfail}), 0);
      check("rst:cnt_tag", int'(oerr_cnt) + int'(otag), 0);
      @(negedge iclk);
      ireset = 1'b1;
      step();

      // No errors
      send({8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 8'd1, 1'b0);
      capture_frame(255);
      check_frame("t1", 255, -1, -1, 0, 0, 1);

      // Single root at p=5
      send(p_single, 8'd2, 1'b0);
      capture_frame(255);
      check_frame("t2", 255, 249, -1, 1, 0, 2);

      // Roots at p=254 and p=0
      send(p_double, 8'd4, 1'b0);
      capture_frame(255);
      check_frame("t3", 255, 0, 254, 2, 0, 4);

      // Upstream failure masks every hit
      send(p_double, 8'd5, 1'b1);
      capture_frame(255);
      check_frame("fail_in", 255, -1, -1, 0, 1, 5);

      // All-zero locator: no roots, no failure
      send(40'h0, 8'd6, 1'b0);
      capture_frame(255);
      check_frame("zero", 255, -1, -1, 0, 0, 6);

      // L(x)=x: degree 1 without roots
      send({8'h00, 8'h00, 8'h00, 8'h01, 8'h00}, 8'd8, 1'b0);
      capture_frame(255);
      check_frame("l0zero", 255, -1, -1, 0, 1, 8);

      // Shortened code, root outside the range
      sel = 1'b1;
      send(p_short, 8'd9, 1'b0);
      capture_frame(100);
      check_frame("short", 100, -1, -1, 0, 1, 9);
      sel = 1'b0;

      // Back-to-back with valid held high
      while (!ordy) step();
      poly = p_single; ptr = 8'd3; failed = 1'b0; val = 1'b1;
      step();
      poly = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01}; ptr = 8'd7;
      capture_frame(255);
      check_frame("b2b_a", 255, 249, -1, 1, 0, 3);
      val = 1'b0;
      capture_frame(255);
      check_frame("b2b_b", 255, -1, -1, 0, 0, 7);

      // Asynchronous reset in the middle of a frame
      send(p_single, 8'd10, 1'b0);
      begin
         int w;
         w = 0;
         while (!oval && w < 8) begin step(); w++; end
      end
      repeat (100) step();
      check("mid:running", int'(oval), 1);
      #2 ireset = 1'b0;
      #1;
      check("mid:outs", int'({oval, oerr, osop, oeop, odecfail}), 0);
      check("mid:cnt_tag", int'(oerr_cnt) + int'(otag), 0);
      @(negedge iclk);
      ireset = 1'b1;
      step();
      check("mid:ordy", int'(ordy), 1);
      check("mid:no_eop", int'(oval | oeop), 0);
      send(p_single, 8'd11, 1'b0);
      capture_frame(255);
      check_frame("after_rst", 255, 249, -1, 1, 0, 11);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
